regs_mp: RTL and testbench
==========================

// Module: regs_mp
// PURPOSE
//  Parametrised general-purpose register file for the core. It replaces the fixed 2R/1W file.
//  - NUM_RD combinational read ports.
//  - One core write port with optional write-to-read bypass.
//  - A JTAG debug port using a 4-phase req/ack handshake.
//  - A post-reset clear sweep that zeroes every register.
//  Sits between decode (reads), writeback (writes) and the JTAG debug module.
// PARAMETERS
//  DATA_W        32  register width in bits
//  ADDR_W        5   address width; depth = 2**ADDR_W; register 0 is hardwired zero
//  NUM_RD        2   number of read ports (>=1)
//  BYPASS        1   1: a same-cycle core write is forwarded to matching read ports
//  CLEAR_ON_RST  1   1: run the clear sweep after reset; 0: contents undefined after reset
// PORTS
//  clk          in   1              clock, all state updates on posedge
//  rst          in   1              synchronous reset, active-high
//  raddr_i      in   NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  rdata_o      out  NUM_RD*DATA_W  read data; port k = bits [k*DATA_W +: DATA_W]
//  we_i         in   1              core write enable
//  waddr_i      in   ADDR_W         core write address
//  wdata_i      in   DATA_W         core write data
//  jtag_req_i   in   1              JTAG access request (level, 4-phase)
//  jtag_we_i    in   1              1: write, 0: read; sampled with request
//  jtag_addr_i  in   ADDR_W         JTAG address; sampled with request
//  jtag_data_i  in   DATA_W         JTAG write data; sampled with request
//  jtag_ack_o   out  1              access done; held until jtag_req_i drops
//  jtag_data_o  out  DATA_W         registered read data, valid while jtag_ack_o=1
//  busy_o       out  1              clear sweep in progress; core must stall
// BEHAVIOUR
//  Reset (rst=1 at a posedge):
//   - jtag_ack_o=0, jtag_data_o=0, clr_cnt=1.
//   - state=CLEAR and busy_o=1 if CLEAR_ON_RST=1; otherwise state=IDLE and busy_o=0.
//   - Reset asserted mid-sweep or mid-handshake aborts it and restarts from this state.
//  FSM states: CLEAR, IDLE, ACK.
//   CLEAR:
//    - Each cycle write 0 to regs[clr_cnt], then clr_cnt++.
//    - After writing address 2**ADDR_W-1, go to IDLE.
//    - busy_o=1 for exactly 2**ADDR_W-1 cycles after reset release.
//    - Core writes and JTAG requests are ignored; ack stays 0.
//   IDLE, when jtag_req_i=1:
//    - Sample we/addr/data.
//    - Read: jtag_data_o <= regs[addr] (0 if addr=0).
//    - Write: regs[addr] <= data (addr 0 ignored); jtag_data_o <= old value.
//    - Next state is ACK, so jtag_ack_o=1 one cycle after req is seen.
//   ACK:
//    - jtag_ack_o stays 1; inputs are ignored.
//    - When jtag_req_i=0, go to IDLE; ack drops the next cycle.
//  Core write:
//   - Performed on posedge in IDLE or ACK when we_i=1 and waddr_i!=0.
//   - Simultaneous core and JTAG write to the same address: JTAG wins.
//   - Core and JTAG writes to different addresses are both performed.
//  Reads are combinational, zero latency:
//   - rdata_k=0 if raddr_k=0.
//   - Otherwise, if BYPASS=1 and we_i=1 and waddr_i==raddr_k and state!=CLEAR, rdata_k=wdata_i.
//   - Otherwise rdata_k=regs[raddr_k].
//   - During CLEAR all rdata=0.
//  Address 0 is never written; a write to it is a silent no-op.
// TESTING
//  - Reset, CLEAR_ON_RST=1, ADDR_W=5 -> busy_o=1 for 31 cycles; afterwards all reads return 0.
//  - Core write x5=0xDEADBEEF with raddr0=5 in the same cycle -> BYPASS=1 gives 0xDEADBEEF that cycle; BYPASS=0 gives 0; next cycle both give 0xDEADBEEF.
//  - JTAG write x7=0x12345678 (req held 4 cycles) -> ack rises 1 cycle after req, stays high until 1 cycle after req drops; rdata for x7=0x12345678.
//  - JTAG write x3=0xAA and core write x3=0xBB in the same cycle -> x3=0xAA; jtag_data_o holds the old x3.
//  - Write x0=0xFFFFFFFF via core and via JTAG -> every read port and jtag_data_o return 0 for x0.
//  - rst pulsed in ACK and at cycle 10 of CLEAR -> ack=0, busy restarts, full 31-cycle sweep completes.

Source files
------------

// File: rtl/regs_mp.sv
// regs_mp: parametrised register file with NUM_RD combinational read ports,
//   one core write port (optional write->read bypass), a 4-phase JTAG debug
//   port, and a post-reset clear sweep. Register 0 always reads as zero.
// Latency: reads are 0 cycles; JTAG ack and read data appear 1 cycle after req is seen.
// Backpressure: busy_o stalls the core during the sweep; JTAG holds ack until req drops.
module regs_mp #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int NUM_RD       = 2,
  parameter int BYPASS       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
  output logic [NUM_RD*DATA_W-1:0]   rdata_o,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       jtag_req_i,
  input  logic                       jtag_we_i,
  input  logic [ADDR_W-1:0]          jtag_addr_i,
  input  logic [DATA_W-1:0]          jtag_data_i,
  output logic                       jtag_ack_o,
  output logic [DATA_W-1:0]          jtag_data_o,
  output logic                       busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  // Sweep starts at 1: register 0 is never stored, so it needs no clearing.
  localparam logic [ADDR_W-1:0] CNT_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam state_e RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   jtag_data_q, jtag_data_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];

  logic                clr_wr;
  logic                core_wr;
  logic                jtag_go;
  logic                jtag_wr;

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: sweep to the last address, then serve one JTAG handshake at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (jtag_req_i) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!jtag_req_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // FSM outputs are pure decodes of the state register, so they are glitch-free.
  always_comb begin
    busy_o     = (state_q == ST_CLEAR);
    jtag_ack_o = (state_q == ST_ACK);
  end

  // Write qualifiers: the sweep owns the array; JTAG is accepted only on the IDLE edge.
  always_comb begin
    clr_wr  = (state_q == ST_CLEAR);
    core_wr = (state_q != ST_CLEAR) && we_i && (waddr_i != '0);
    jtag_go = (state_q == ST_IDLE) && jtag_req_i;
    jtag_wr = jtag_go && jtag_we_i && (jtag_addr_i != '0);
  end

  // Sweep counter advances once per CLEAR cycle; it wraps harmlessly on exit.
  always_comb begin
    clr_cnt_d = clr_cnt_q;
    if (clr_wr) begin
      clr_cnt_d = clr_cnt_q + CNT_ONE;
    end
  end

  // JTAG read-back captures the pre-write contents, for both reads and writes.
  always_comb begin
    jtag_data_d = jtag_data_q;
    if (jtag_go) begin
      if (jtag_addr_i == '0) begin
        jtag_data_d = '0;
      end else begin
        jtag_data_d = regs_q[jtag_addr_i];
      end
    end
  end

  // Array next value: JTAG is applied last so it wins an address collision with the core.
  always_comb begin
    regs_d = regs_q;
    if (clr_wr) begin
      regs_d[clr_cnt_q] = '0;
    end
    if (core_wr) begin
      regs_d[waddr_i] = wdata_i;
    end
    if (jtag_wr) begin
      regs_d[jtag_addr_i] = jtag_data_i;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_q   <= CNT_ONE;
      jtag_data_q <= '0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      jtag_data_q <= jtag_data_d;
    end
  end

  // Storage has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q <= regs_d;
    end
  end

  assign jtag_data_o = jtag_data_q;

  // Read ports: x0 and the sweep force zero; bypass forwards a same-cycle core write.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr_i[k*ADDR_W +: ADDR_W];

    // Per-port read mux, priority: zero cases, then bypass, then storage.
    always_comb begin
      rd = regs_q[ra];
      if ((BYPASS != 0) && we_i && (waddr_i == ra)) begin
        rd = wdata_i;
      end
      if ((ra == '0) || (state_q == ST_CLEAR)) begin
        rd = '0;
      end
    end

    assign rdata_o[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regs_mp.sv
// tb_regs_mp: directed tests for regs_mp with a bypass and a non-bypass instance
//   driven from the same stimulus.
module tb_regs_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata, rdata_nb;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        jreq = 1'b0;
  logic        jwe = 1'b0;
  logic [4:0]  jaddr = '0;
  logic [31:0] jdin = '0;
  logic        ack, ack_nb;
  logic [31:0] jdout, jdout_nb;
  logic        busy, busy_nb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regs_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .CLEAR_ON_RST(1)) dut (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .jtag_req_i(jreq), .jtag_we_i(jwe), .jtag_addr_i(jaddr), .jtag_data_i(jdin),
    .jtag_ack_o(ack), .jtag_data_o(jdout), .busy_o(busy)
  );

  regs_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .CLEAR_ON_RST(1)) dut_nb (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_nb),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .jtag_req_i(jreq), .jtag_we_i(jwe), .jtag_addr_i(jaddr), .jtag_data_i(jdin),
    .jtag_ack_o(ack_nb), .jtag_data_o(jdout_nb), .busy_o(busy_nb)
  );

  function automatic logic [31:0] rd(input int k);
    return rdata[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_nb(input int k);
    return rdata_nb[k*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_tests++; if (jdout !== 32'h0) begin n_fail++; $display("FAIL reset_jdata: got %h expected 0", jdout); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    // a core write attempted in the first sweep cycle must neither bypass nor land
    we = 1'b1; waddr = 5'd31; wdata = 32'h5A5A5A5A; raddr[4:0] = 5'd31;
    rst = 1'b0;
    #1;
    n_tests++; if (rd(0) !== 32'h0) begin n_fail++; $display("FAIL clear_read: got %h expected 0", rd(0)); end
    we = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    n_tests++; if (n !== 31) begin n_fail++; $display("FAIL sweep_len: got %0d expected 31", n); end
    for (int a = 0; a < 32; a++) begin
      raddr[4:0] = 5'(a);
      raddr[9:5] = 5'(31 - a);
      #1;
      n_tests++; if (rd(0) !== 32'h0 || rd(1) !== 32'h0) begin
        n_fail++; $display("FAIL post_clear_x%0d: got %h/%h expected 0/0", a, rd(0), rd(1));
      end
    end
  endtask

  task automatic test_bypass();
    tick();
    raddr[4:0] = 5'd5; raddr[9:5] = 5'd0;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    #1;
    n_tests++; if (rd(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_on: got %h expected deadbeef", rd(0)); end
    n_tests++; if (rd_nb(0) !== 32'h0) begin n_fail++; $display("FAIL bypass_off: got %h expected 0", rd_nb(0)); end
    n_tests++; if (rd(1) !== 32'h0) begin n_fail++; $display("FAIL bypass_x0: got %h expected 0", rd(1)); end
    tick();
    we = 1'b0;
    #1;
    n_tests++; if (rd(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_on: got %h expected deadbeef", rd(0)); end
    n_tests++; if (rd_nb(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_off: got %h expected deadbeef", rd_nb(0)); end
  endtask

  task automatic test_jtag_write();
    tick();
    jreq = 1'b1; jwe = 1'b1; jaddr = 5'd7; jdin = 32'h12345678;
    #1;
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_early: got %b expected 0", ack); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ack_held_%0d: got %b expected 1", i, ack); end
      if (i == 0) begin
        n_tests++; if (jdout !== 32'h0) begin n_fail++; $display("FAIL jwr_old: got %h expected 0", jdout); end
      end
    end
    jreq = 1'b0;
    #1;
    n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ack_after_drop: got %b expected 1", ack); end
    tick();
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_fall: got %b expected 0", ack); end
    raddr[9:5] = 5'd7;
    #1;
    n_tests++; if (rd(1) !== 32'h12345678) begin n_fail++; $display("FAIL jwr_x7: got %h expected 12345678", rd(1)); end
    // JTAG read of x5
    tick();
    jreq = 1'b1; jwe = 1'b0; jaddr = 5'd5;
    tick();
    n_tests++; if (ack !== 1'b1 || jdout !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL jrd_x5: got ack=%b data=%h expected ack=1 data=deadbeef", ack, jdout);
    end
    jreq = 1'b0;
    tick();
    tick();
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL jrd_ack_fall: got %b expected 0", ack); end
  endtask

  task automatic test_collision();
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'hBB;
    jreq = 1'b1; jwe = 1'b1; jaddr = 5'd3; jdin = 32'hAA;
    tick();
    we = 1'b0; raddr[4:0] = 5'd3;
    #1;
    n_tests++; if (rd(0) !== 32'hAA) begin n_fail++; $display("FAIL coll_x3: got %h expected aa", rd(0)); end
    n_tests++; if (jdout !== 32'h11) begin n_fail++; $display("FAIL coll_old: got %h expected 11", jdout); end
    // core write while the handshake sits in ACK is still performed
    we = 1'b1; waddr = 5'd8; wdata = 32'h88;
    tick();
    we = 1'b0; jreq = 1'b0; raddr[4:0] = 5'd8;
    #1;
    n_tests++; if (rd(0) !== 32'h88) begin n_fail++; $display("FAIL core_in_ack: got %h expected 88", rd(0)); end
    tick();
    // different addresses in the same cycle: both land
    we = 1'b1; waddr = 5'd4; wdata = 32'h44;
    jreq = 1'b1; jwe = 1'b1; jaddr = 5'd6; jdin = 32'h66;
    tick();
    we = 1'b0; jreq = 1'b0; raddr[4:0] = 5'd4; raddr[9:5] = 5'd6;
    #1;
    n_tests++; if (rd(0) !== 32'h44 || rd(1) !== 32'h66) begin
      n_fail++; $display("FAIL dual_write: got %h/%h expected 44/66", rd(0), rd(1));
    end
    tick();
  endtask

  task automatic test_x0();
    tick();
    raddr = '0;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    #1;
    n_tests++; if (rd(0) !== 32'h0 || rd(1) !== 32'h0 || rd_nb(0) !== 32'h0) begin
      n_fail++; $display("FAIL x0_bypass: got %h/%h/%h expected 0", rd(0), rd(1), rd_nb(0));
    end
    tick();
    we = 1'b0;
    jreq = 1'b1; jwe = 1'b1; jaddr = 5'd0; jdin = 32'hFFFFFFFF;
    #1;
    n_tests++; if (rd(0) !== 32'h0) begin n_fail++; $display("FAIL x0_core: got %h expected 0", rd(0)); end
    tick();
    n_tests++; if (ack !== 1'b1 || jdout !== 32'h0) begin
      n_fail++; $display("FAIL x0_jwr: got ack=%b data=%h expected ack=1 data=0", ack, jdout);
    end
    jreq = 1'b0;
    tick();
    jreq = 1'b1; jwe = 1'b0; jaddr = 5'd0;
    tick();
    n_tests++; if (jdout !== 32'h0) begin n_fail++; $display("FAIL x0_jrd: got %h expected 0", jdout); end
    jreq = 1'b0;
    #1;
    n_tests++; if (rd(0) !== 32'h0 || rd(1) !== 32'h0) begin
      n_fail++; $display("FAIL x0_final: got %h/%h expected 0", rd(0), rd(1));
    end
    tick();
  endtask

  task automatic test_rst_mid();
    int n;
    tick();
    jreq = 1'b1; jwe = 1'b0; jaddr = 5'd7;
    tick();
    n_tests++; if (ack !== 1'b1 || jdout !== 32'h12345678) begin
      n_fail++; $display("FAIL pre_rst_ack: got ack=%b data=%h expected ack=1 data=12345678", ack, jdout);
    end
    rst = 1'b1;
    tick();
    n_tests++; if (ack !== 1'b0 || busy !== 1'b1 || jdout !== 32'h0) begin
      n_fail++; $display("FAIL rst_in_ack: got ack=%b busy=%b data=%h expected 0/1/0", ack, busy, jdout);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (busy !== 1'b1 || ack !== 1'b0) begin
        n_fail++; $display("FAIL sweep1_c%0d: got busy=%b ack=%b expected 1/0", i, busy, ack);
      end
      tick();
    end
    rst = 1'b1; jreq = 1'b0;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 20) begin
        we = 1'b1; waddr = 5'd2; wdata = 32'h22; raddr[4:0] = 5'd2;
        #1;
        n_tests++; if (rd(0) !== 32'h0) begin n_fail++; $display("FAIL clear_bypass: got %h expected 0", rd(0)); end
      end else begin
        we = 1'b0;
      end
      n++;
      tick();
    end
    we = 1'b0;
    n_tests++; if (n !== 31) begin n_fail++; $display("FAIL sweep2_len: got %0d expected 31", n); end
    raddr[4:0] = 5'd2; raddr[9:5] = 5'd7;
    #1;
    n_tests++; if (rd(0) !== 32'h0 || rd(1) !== 32'h0) begin
      n_fail++; $display("FAIL sweep2_x2_x7: got %h/%h expected 0/0", rd(0), rd(1));
    end
    raddr[4:0] = 5'd3; raddr[9:5] = 5'd5;
    #1;
    n_tests++; if (rd(0) !== 32'h0 || rd(1) !== 32'h0 || ack !== 1'b0) begin
      n_fail++; $display("FAIL sweep2_x3_x5: got %h/%h ack=%b expected 0/0 ack=0", rd(0), rd(1), ack);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_jtag_write();
    test_collision();
    test_x0();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
